btb_update_ctrl: RTL and testbench
==================================

BTB_UPDATE_CTRL -- requirements
Module: btb_update_ctrl

Interface
REQ-001 Parameter: FIFO_DEPTH, 4, number of pending BTB write entries (power of two, minimum 2).
REQ-002 Parameter: IDX_W, 6, BTB and counter-table index width (64 entries).
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 clk  in  1  sole clock; all state updates on posedge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 res_valid  in  1  resolved branch from EX is presented.
REQ-007 res_ready  out  1  block accepts the resolved branch this cycle.
REQ-008 res_pc  in  32  PC of the resolved branch.
REQ-009 res_taken  in  1  actual branch direction.
REQ-010 res_target  in  32  actual taken target.
REQ-011 res_pred_taken  in  1  direction predicted at fetch.
REQ-012 res_pred_target  in  32  target predicted at fetch (BTB output).
REQ-013 fetch_busy  in  1  BTB lookup occupies the BTB port this cycle; writes are deferred.
REQ-014 btb_write  out  1  one-cycle BTB write strobe.
REQ-015 btb_index  out  IDX_W  BTB entry index to write.
REQ-016 btb_target  out  32  target value to write.
REQ-017 q_index  in  IDX_W  fetch-side direction query index.
REQ-018 q_taken  out  1  combinational predicted direction, counter[q_index] MSB.
REQ-019 mispredict  out  1  one-cycle flush pulse.
REQ-020 redirect_pc  out  32  correct fetch PC, valid while mispredict=1.
REQ-021 mispredict_cnt  out  16  saturating mispredict counter.

Function
REQ-022 res_ready SHALL equal NOT fifo_full; a handshake completes when res_valid=1 and res_ready=1.
REQ-023 Index SHALL be res_pc[IDX_W+1:2].
REQ-024 A mispredict SHALL be flagged on accept when res_taken != res_pred_taken, or when res_taken=1, res_pred_taken=1 and res_target != res_pred_target.
REQ-025 mispredict SHALL pulse high exactly one cycle after the accepting edge; redirect_pc SHALL be res_target if taken, else res_pc+4 (mod 2^32).
REQ-026 mispredict_cnt SHALL increment on each flagged mispredict and hold at 0xFFFF.
REQ-027 The counter table SHALL hold 2^IDX_W 2-bit saturating counters; on accept, taken increments toward 11 and not-taken decrements toward 00.
REQ-028 On accept with res_taken=1 and (res_pred_taken=0 or res_target != res_pred_target), the block SHALL enqueue {index, res_target}; otherwise nothing is enqueued.
REQ-029 Drain FSM states: IDLE and WRITE.
  - IDLE -> WRITE when FIFO is non-empty and fetch_busy=0.
  - WRITE: btb_write=1 for exactly one cycle, driving the head entry; the entry is popped; the FSM returns to IDLE.
REQ-030 btb_write=0 in every cycle where fetch_busy=1; btb_index and btb_target SHALL be stable while btb_write=1.
REQ-031 Entries SHALL drain in FIFO order; duplicate indices are not merged.
REQ-032 Simultaneous enqueue and pop SHALL keep the occupancy unchanged; when full, no enqueue occurs even if a pop happens in the same cycle.
REQ-033 FIFO pointers SHALL wrap modulo FIFO_DEPTH; full and empty are distinguished by an extra pointer bit.

Reset
REQ-034 While reset=0: res_ready=0, btb_write=0, mispredict=0, redirect_pc=0, mispredict_cnt=0, FIFO empty, FSM=IDLE, all counters=01.
REQ-035 Reset asserted mid-operation SHALL discard all pending entries immediately, with no partial write.
REQ-036 res_ready SHALL rise in the first cycle after reset deasserts.

Verification
REQ-037 Accept pc=0x40, taken=1, target=0x100, pred_taken=0 -> next cycle mispredict=1, redirect_pc=0x100; btb_write=1 with index=0x10, target=0x100; counter[0x10]=10.
REQ-038 Accept pc=0x40, taken=0, pred_taken=1 -> mispredict=1, redirect_pc=0x44; no BTB write; counter decrements.
REQ-039 Hold fetch_busy=1 and accept 5 entries that each need a write -> res_ready=0 after the 4th; release fetch_busy -> exactly 4 writes in order, then res_ready=1.
REQ-040 Correct taken prediction with matching target -> no mispredict, no write; counter at 11 stays 11 on a further taken.
REQ-041 Assert reset with 3 entries queued -> btb_write never asserts; mispredict_cnt=0; q_taken=0 for all indices.
REQ-042 Preload mispredict_cnt to 0xFFFE and force two mispredicts -> counter reads 0xFFFF and holds.

Source files
------------

// File: rtl/btb_update_ctrl_if.sv
// Resolve-side handshake, BTB write port, direction query and flush signals of btb_update_ctrl.
// The slave modport is the controller; the master modport is the pipeline / BTB side.
interface btb_update_ctrl_if #(
   parameter int IDX_W = 6
);
   logic             res_valid;
   logic             res_ready;
   logic [31:0]      res_pc;
   logic             res_taken;
   logic [31:0]      res_target;
   logic             res_pred_taken;
   logic [31:0]      res_pred_target;
   logic             fetch_busy;
   logic             btb_write;
   logic [IDX_W-1:0] btb_index;
   logic [31:0]      btb_target;
   logic [IDX_W-1:0] q_index;
   logic             q_taken;
   logic             mispredict;
   logic [31:0]      redirect_pc;
   logic [15:0]      mispredict_cnt;

   modport slave (
      input  res_valid, res_pc, res_taken, res_target, res_pred_taken, res_pred_target,
      input  fetch_busy, q_index,
      output res_ready, btb_write, btb_index, btb_target, q_taken,
      output mispredict, redirect_pc, mispredict_cnt
   );

   modport master (
      output res_valid, res_pc, res_taken, res_target, res_pred_taken, res_pred_target,
      output fetch_busy, q_index,
      input  res_ready, btb_write, btb_index, btb_target, q_taken,
      input  mispredict, redirect_pc, mispredict_cnt
   );
endinterface

// File: rtl/btb_update_ctrl.sv
// Branch-resolution update controller: direction counters, mispredict flush, and a small
// FIFO of pending BTB writes drained whenever fetch leaves the BTB port free.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   S_IDLE  | no write in flight; waits for a queued entry and a free BTB port
//   S_WRITE | head entry presented; strobes btb_write on a cycle fetch is idle
module btb_update_ctrl #(
   parameter int FIFO_DEPTH = 4,
   parameter int IDX_W      = 6
) (
   input logic              clk,
   input logic              reset,
   btb_update_ctrl_if.slave bus
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int N_CTR = 1 << IDX_W;

   typedef enum logic {S_IDLE, S_WRITE} state_t;

   state_t           state_q, state_d;
   logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
   logic [IDX_W-1:0] fifo_idx_q [FIFO_DEPTH];
   logic [IDX_W-1:0] fifo_idx_d [FIFO_DEPTH];
   logic [31:0]      fifo_tgt_q [FIFO_DEPTH];
   logic [31:0]      fifo_tgt_d [FIFO_DEPTH];
   logic [1:0]       ctr_q [N_CTR];
   logic [1:0]       ctr_d [N_CTR];
   logic             run_q, run_d;
   logic             mispredict_q, mispredict_d;
   logic [31:0]      redirect_q, redirect_d;
   logic [15:0]      mp_cnt_q, mp_cnt_d;

   logic             fifo_full, fifo_empty;
   logic             accept, flag_mp, do_enq, do_pop;
   logic [IDX_W-1:0] res_idx;
   logic             tgt_differs;
   logic [1:0]       ctr_cur;

   // Extra pointer bit separates full (MSBs differ) from empty (pointers equal).
   assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                       (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
   assign fifo_empty = (wr_ptr_q == rd_ptr_q);

   assign bus.res_ready = run_q & ~fifo_full;
   assign accept        = bus.res_valid & bus.res_ready;
   assign res_idx       = bus.res_pc[IDX_W+1:2];
   assign tgt_differs   = (bus.res_target != bus.res_pred_target);
   assign flag_mp       = accept & ((bus.res_taken != bus.res_pred_taken) |
                                    (bus.res_taken & bus.res_pred_taken & tgt_differs));
   assign do_enq        = accept & bus.res_taken & (~bus.res_pred_taken | tgt_differs);
   assign ctr_cur       = ctr_q[res_idx];

   // Strobe is gated by fetch_busy so a late fetch lookup simply postpones the write.
   assign bus.btb_write  = (state_q == S_WRITE) & ~bus.fetch_busy;
   assign do_pop         = bus.btb_write;
   assign bus.btb_index  = fifo_idx_q[rd_ptr_q[PTR_W-1:0]];
   assign bus.btb_target = fifo_tgt_q[rd_ptr_q[PTR_W-1:0]];

   assign bus.q_taken        = ctr_q[bus.q_index][1];
   assign bus.mispredict     = mispredict_q;
   assign bus.redirect_pc    = redirect_q;
   assign bus.mispredict_cnt = mp_cnt_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (!fifo_empty && !bus.fetch_busy) state_d = S_WRITE;
         S_WRITE: if (!bus.fetch_busy)                state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      fifo_idx_d = fifo_idx_q;
      fifo_tgt_d = fifo_tgt_q;
      if (do_enq) begin
         fifo_idx_d[wr_ptr_q[PTR_W-1:0]] = res_idx;
         fifo_tgt_d[wr_ptr_q[PTR_W-1:0]] = bus.res_target;
         wr_ptr_d                        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
   end

   always_comb begin
      ctr_d = ctr_q;
      if (accept) begin
         if (bus.res_taken && ctr_cur != 2'b11) begin
            ctr_d[res_idx] = ctr_cur + 2'b01;
         end else if (!bus.res_taken && ctr_cur != 2'b00) begin
            ctr_d[res_idx] = ctr_cur - 2'b01;
         end
      end
   end

   always_comb begin
      run_d        = 1'b1;
      mispredict_d = flag_mp;
      redirect_d   = redirect_q;
      mp_cnt_d     = mp_cnt_q;
      if (flag_mp) begin
         redirect_d = bus.res_taken ? bus.res_target : (bus.res_pc + 32'd4);
         if (mp_cnt_q != 16'hFFFF) begin
            mp_cnt_d = mp_cnt_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         run_q        <= 1'b0;
         mispredict_q <= 1'b0;
         redirect_q   <= '0;
         mp_cnt_q     <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_idx_q[i] <= '0;
            fifo_tgt_q[i] <= '0;
         end
         for (int i = 0; i < N_CTR; i++) begin
            ctr_q[i] <= 2'b01;
         end
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         run_q        <= run_d;
         mispredict_q <= mispredict_d;
         redirect_q   <= redirect_d;
         mp_cnt_q     <= mp_cnt_d;
         fifo_idx_q   <= fifo_idx_d;
         fifo_tgt_q   <= fifo_tgt_d;
         ctr_q        <= ctr_d;
      end
   end
endmodule

// File: tb/tb_btb_update_ctrl.sv
// Directed bench for btb_update_ctrl: a table of single-branch vectors plus hand-written
// sequences for FIFO fill/drain, mid-operation reset and mispredict counter saturation.
module tb_btb_update_ctrl;
   localparam int IDX_W      = 6;
   localparam int FIFO_DEPTH = 4;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   btb_update_ctrl_if #(.IDX_W(IDX_W)) bus ();

   btb_update_ctrl #(.FIFO_DEPTH(FIFO_DEPTH), .IDX_W(IDX_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic [31:0]      pc;
      logic             taken;
      logic [31:0]      tgt;
      logic             pt;
      logic [31:0]      ptgt;
      logic             exp_mp;
      logic [31:0]      exp_redir;
      logic             exp_wr;
      logic [IDX_W-1:0] exp_idx;
      logic             exp_q;
   } vec_t;

   int   n_pass = 0;
   int   n_total = 0;
   int   model_cnt = 0;
   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   function automatic vec_t mk(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                               input logic pt, input logic [31:0] ptgt, input logic exp_mp,
                               input logic [31:0] exp_redir, input logic exp_wr,
                               input logic [IDX_W-1:0] exp_idx, input logic exp_q);
      vec_t v;
      v.pc = pc; v.taken = taken; v.tgt = tgt; v.pt = pt; v.ptgt = ptgt;
      v.exp_mp = exp_mp; v.exp_redir = exp_redir; v.exp_wr = exp_wr;
      v.exp_idx = exp_idx; v.exp_q = exp_q;
      return v;
   endfunction

   task automatic drive_res(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                            input logic pt, input logic [31:0] ptgt);
      bus.res_valid       = 1'b1;
      bus.res_pc          = pc;
      bus.res_taken       = taken;
      bus.res_target      = tgt;
      bus.res_pred_taken  = pt;
      bus.res_pred_target = ptgt;
   endtask

   task automatic run_vec(input vec_t v, input int n);
      int               nw = 0;
      logic [IDX_W-1:0] wi = '0;
      logic [31:0]      wt = '0;
      @(negedge clk);
      drive_res(v.pc, v.taken, v.tgt, v.pt, v.ptgt);
      bus.q_index = v.exp_idx;
      check($sformatf("v%0d res_ready", n), 32'(bus.res_ready), 32'd1);
      @(posedge clk); #1;
      bus.res_valid = 1'b0;
      check($sformatf("v%0d mispredict", n), 32'(bus.mispredict), 32'(v.exp_mp));
      if (v.exp_mp) check($sformatf("v%0d redirect_pc", n), bus.redirect_pc, v.exp_redir);
      check($sformatf("v%0d q_taken", n), 32'(bus.q_taken), 32'(v.exp_q));
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         if (c == 0) check($sformatf("v%0d mispredict_end", n), 32'(bus.mispredict), 32'd0);
         if (bus.btb_write) begin
            nw++;
            wi = bus.btb_index;
            wt = bus.btb_target;
         end
      end
      check($sformatf("v%0d write_count", n), nw, 32'(v.exp_wr));
      if (v.exp_wr) begin
         check($sformatf("v%0d btb_index", n), 32'(wi), 32'(v.exp_idx));
         check($sformatf("v%0d btb_target", n), wt, v.tgt);
      end
      if (v.exp_mp) model_cnt++;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached before end of test");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0]      a_pc  [5];
      logic [31:0]      a_tgt [5];
      logic [IDX_W-1:0] a_idx [5];
      logic [IDX_W-1:0] got_idx [8];
      logic [31:0]      got_tgt [8];
      int               nw;
      int               busy_wr;
      int               bad_q;

      bus.res_valid = 1'b0; bus.res_pc = '0; bus.res_taken = 1'b0; bus.res_target = '0;
      bus.res_pred_taken = 1'b0; bus.res_pred_target = '0; bus.fetch_busy = 1'b0;
      bus.q_index = '0;

      // pc, taken, tgt, pred_taken, pred_tgt, mp, redirect, write, idx, q_taken after
      vecs.push_back(mk(32'h40,       1, 32'h100, 0, 32'h0,   1, 32'h100, 1, 6'h10, 1));
      vecs.push_back(mk(32'h40,       0, 32'h0,   1, 32'h100, 1, 32'h44,  0, 6'h10, 0));
      vecs.push_back(mk(32'h80,       1, 32'h200, 1, 32'h200, 0, 32'h0,   0, 6'h20, 1));
      vecs.push_back(mk(32'h80,       1, 32'h200, 1, 32'h200, 0, 32'h0,   0, 6'h20, 1));
      vecs.push_back(mk(32'h80,       1, 32'h200, 1, 32'h200, 0, 32'h0,   0, 6'h20, 1));
      vecs.push_back(mk(32'h80,       0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 6'h20, 1));
      vecs.push_back(mk(32'h80,       0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 6'h20, 0));
      vecs.push_back(mk(32'hFC,       1, 32'h300, 1, 32'h304, 1, 32'h300, 1, 6'h3F, 1));
      vecs.push_back(mk(32'hFFFFFFFC, 0, 32'h0,   1, 32'h500, 1, 32'h0,   0, 6'h3F, 0));
      vecs.push_back(mk(32'h104,      0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 6'h01, 0));
      vecs.push_back(mk(32'h104,      0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 6'h01, 0));
      vecs.push_back(mk(32'h104,      1, 32'h700, 1, 32'h700, 0, 32'h0,   0, 6'h01, 0));
      vecs.push_back(mk(32'h104,      1, 32'h700, 1, 32'h700, 0, 32'h0,   0, 6'h01, 1));

      // Reset state
      repeat (3) @(negedge clk);
      check("rst res_ready", 32'(bus.res_ready), 32'd0);
      check("rst btb_write", 32'(bus.btb_write), 32'd0);
      check("rst mispredict", 32'(bus.mispredict), 32'd0);
      check("rst redirect_pc", bus.redirect_pc, 32'd0);
      check("rst mispredict_cnt", 32'(bus.mispredict_cnt), 32'd0);
      check("rst q_taken", 32'(bus.q_taken), 32'd0);
      reset = 1'b1;
      @(posedge clk); #1;
      check("post-rst res_ready", 32'(bus.res_ready), 32'd1);

      foreach (vecs[i]) run_vec(vecs[i], i);

      // Fill FIFO while fetch holds the port, then drain with fetch_busy toggling.
      a_pc  = '{32'h40, 32'h140, 32'h80, 32'h44, 32'h48};
      a_tgt = '{32'h1000, 32'h2000, 32'h3000, 32'h4000, 32'h5000};
      a_idx = '{6'h10, 6'h10, 6'h20, 6'h11, 6'h12};
      busy_wr = 0;
      nw = 0;
      @(negedge clk);
      bus.fetch_busy = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         drive_res(a_pc[k], 1'b1, a_tgt[k], 1'b0, 32'h0);
         if (bus.btb_write) busy_wr++;
         check($sformatf("fill%0d res_ready", k), 32'(bus.res_ready), (k < 4) ? 32'd1 : 32'd0);
         @(posedge clk);
      end
      @(negedge clk);
      bus.res_valid = 1'b0;
      model_cnt += 4;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         bus.fetch_busy = (c % 3 == 1);
         #1;
         if (bus.fetch_busy && bus.btb_write) busy_wr++;
         if (bus.btb_write && !bus.fetch_busy) begin
            if (nw < 8) begin
               got_idx[nw] = bus.btb_index;
               got_tgt[nw] = bus.btb_target;
            end
            nw++;
         end
      end
      bus.fetch_busy = 1'b0;
      check("drain write while busy", busy_wr, 32'd0);
      check("drain write count", nw, 32'd4);
      for (int k = 0; k < 4; k++) begin
         if (k < nw) begin
            check($sformatf("drain%0d index", k), 32'(got_idx[k]), 32'(a_idx[k]));
            check($sformatf("drain%0d target", k), got_tgt[k], a_tgt[k]);
         end
      end
      @(negedge clk);
      check("drain res_ready", 32'(bus.res_ready), 32'd1);
      check("mispredict_cnt model", 32'(bus.mispredict_cnt), 32'(model_cnt));

      // Reset with three entries queued: nothing may be written afterwards.
      bus.fetch_busy = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         drive_res(a_pc[k], 1'b1, a_tgt[k], 1'b0, 32'h0);
         @(posedge clk);
      end
      @(negedge clk);
      bus.res_valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      #1;
      bus.fetch_busy = 1'b0;
      busy_wr = 0;
      check("midrst res_ready", 32'(bus.res_ready), 32'd0);
      check("midrst mispredict_cnt", 32'(bus.mispredict_cnt), 32'd0);
      check("midrst redirect_pc", bus.redirect_pc, 32'd0);
      bad_q = 0;
      for (int i = 0; i < (1 << IDX_W); i++) begin
         bus.q_index = IDX_W'(i);
         #1;
         if (bus.q_taken !== 1'b0) bad_q++;
      end
      check("midrst q_taken nonzero count", bad_q, 32'd0);
      repeat (3) begin
         @(negedge clk);
         if (bus.btb_write !== 1'b0) busy_wr++;
      end
      reset = 1'b1;
      @(posedge clk); #1;
      check("midrst post res_ready", 32'(bus.res_ready), 32'd1);
      repeat (8) begin
         @(negedge clk);
         if (bus.btb_write !== 1'b0) busy_wr++;
      end
      check("midrst stray writes", busy_wr, 32'd0);

      // Saturation of the mispredict counter.
      @(negedge clk);
      drive_res(32'h0, 1'b0, 32'h0, 1'b1, 32'h0);
      repeat (65534) @(posedge clk);
      @(negedge clk);
      bus.res_valid = 1'b0;
      check("sat cnt 0xFFFE", 32'(bus.mispredict_cnt), 32'hFFFE);
      check("sat redirect_pc", bus.redirect_pc, 32'h4);
      drive_res(32'h0, 1'b0, 32'h0, 1'b1, 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      bus.res_valid = 1'b0;
      check("sat cnt 0xFFFF", 32'(bus.mispredict_cnt), 32'hFFFF);
      drive_res(32'h0, 1'b0, 32'h0, 1'b1, 32'h0);
      @(posedge clk); #1;
      bus.res_valid = 1'b0;
      check("sat mispredict pulse", 32'(bus.mispredict), 32'd1);
      check("sat cnt hold", 32'(bus.mispredict_cnt), 32'hFFFF);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
